// File: rtl/count_mon_pkg.sv
// Shared constants and state encoding for the count stream monitor.
package count_mon_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int MAX_VAL_DEF = 15;
  localparam int LOCK_N_DEF  = 2;
  localparam int STAT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Up-counter that sticks at all ones; synchronous active-low clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Locks onto a free-running up-counter stream and classifies deviations.
//   state  | meaning
//   IDLE   | disabled or just reset; next enabled sample is captured as-is
//   ACQ    | counting consecutive correct increments toward lock
//   LOCKED | stream is trusted; deviations raise restart/error events
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF,
  parameter int LOCK_N  = LOCK_N_DEF,
  parameter int STAT_W  = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              err_pulse,
  output logic              restart_pulse,
  output logic              wrap_pulse,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] restart_cnt,
  output logic [STAT_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0]  last_count
);

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VAL);
  localparam logic [3:0]       LOCKV = 4'(LOCK_N);

  mon_state_t       state;
  logic [3:0]       match;
  logic [WIDTH-1:0] exp_val;
  logic             in_range;
  logic             hit;
  logic             err_ev;
  logic             restart_ev;
  logic             wrap_ev;

  // Only a partial-range counter can present values beyond its terminal count.
  if (MAX_VAL == (1 << WIDTH) - 1) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (count <= MAXV);
  end

  always_comb begin
    exp_val    = (last_count == MAXV) ? '0 : last_count + 1'b1;
    hit        = (count == exp_val) && in_range;
    err_ev     = en && (state == LOCKED) && !hit && (count != '0);
    restart_ev = en && (state == LOCKED) && !hit && (count == '0);
    wrap_ev    = en && (state == LOCKED) && hit && (exp_val == '0);
  end

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_ev),
    .cnt (err_cnt)
  );

  sat_counter #(.W(STAT_W)) u_restart_cnt (
    .clk (clk),
    .rst (rst),
    .inc (restart_ev),
    .cnt (restart_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      locked        <= 1'b0;
      match         <= '0;
      last_count    <= '0;
      err_pulse     <= 1'b0;
      restart_pulse <= 1'b0;
      wrap_pulse    <= 1'b0;
      wrap_cnt      <= '0;
    end else begin
      err_pulse     <= err_ev;
      restart_pulse <= restart_ev;
      wrap_pulse    <= wrap_ev;
      if (wrap_ev) begin
        wrap_cnt <= wrap_cnt + 1'b1;
      end

      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            last_count <= count;
            match      <= '0;
            state      <= ACQ;
          end
          ACQ: begin
            last_count <= count;
            if (hit) begin
              match <= match + 1'b1;
              if ((match + 1'b1) == LOCKV) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match <= '0;
            end
          end
          LOCKED: begin
            last_count <= count;
            if (!hit) begin
              match  <= '0;
              state  <= ACQ;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
            match  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Randomized and directed bench for count_monitor against a behavioural stream model.
module tb_count_monitor;

  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 15;
  localparam int LOCK_N  = 2;
  localparam int STAT_W  = 8;
  localparam int SAT_MAX = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic [WIDTH-1:0]  count = '0;
  logic              locked;
  logic              err_pulse;
  logic              restart_pulse;
  logic              wrap_pulse;
  logic [STAT_W-1:0] err_cnt;
  logic [STAT_W-1:0] restart_cnt;
  logic [STAT_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]  last_count;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model: stream tracking in plain integers
  bit m_active, m_locked;
  int m_run, m_last, m_err, m_rst, m_wrap;
  bit e_errp, e_rstp, e_wrapp;

  count_monitor #(
    .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .LOCK_N(LOCK_N), .STAT_W(STAT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .count         (count),
    .locked        (locked),
    .err_pulse     (err_pulse),
    .restart_pulse (restart_pulse),
    .wrap_pulse    (wrap_pulse),
    .err_cnt       (err_cnt),
    .restart_cnt   (restart_cnt),
    .wrap_cnt      (wrap_cnt),
    .last_count    (last_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input int c);
    int  nxt;
    bit  good;
    e_errp  = 0;
    e_rstp  = 0;
    e_wrapp = 0;
    if (!r) begin
      m_active = 0; m_locked = 0; m_run = 0; m_last = 0;
      m_err = 0; m_rst = 0; m_wrap = 0;
    end else if (!e) begin
      m_active = 0;
      m_locked = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_last   = c;
      m_run    = 0;
    end else begin
      nxt  = (m_last + 1) % (MAX_VAL + 1);
      good = (c == nxt) && (c <= MAX_VAL);
      if (m_locked) begin
        if (good) begin
          if (nxt == 0) begin
            e_wrapp = 1;
            m_wrap  = (m_wrap + 1) % (1 << STAT_W);
          end
        end else begin
          m_locked = 0;
          m_run    = 0;
          if (c == 0) begin
            e_rstp = 1;
            if (m_rst < SAT_MAX) m_rst++;
          end else begin
            e_errp = 1;
            if (m_err < SAT_MAX) m_err++;
          end
        end
      end else begin
        if (good) begin
          m_run++;
          if (m_run >= LOCK_N) m_locked = 1;
        end else begin
          m_run = 0;
        end
      end
      m_last = c;
    end
  endtask

  task automatic drive(input bit r, input bit e, input int c);
    rst   = r;
    en    = e;
    count = WIDTH'(c);
    @(posedge clk);
    model_step(r, e, c);
    #1;
    check_val("locked",        int'(locked),        int'(m_locked));
    check_val("err_pulse",     int'(err_pulse),     int'(e_errp));
    check_val("restart_pulse", int'(restart_pulse), int'(e_rstp));
    check_val("wrap_pulse",    int'(wrap_pulse),    int'(e_wrapp));
    check_val("err_cnt",       int'(err_cnt),       m_err);
    check_val("restart_cnt",   int'(restart_cnt),   m_rst);
    check_val("wrap_cnt",      int'(wrap_cnt),      m_wrap);
    check_val("last_count",    int'(last_count),    m_last);
    check_val("pulse_excl",
              (int'(err_pulse) + int'(restart_pulse) + int'(wrap_pulse)) <= 1 ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    drive(0, 1, 7);
  endtask

  initial begin
    int v;
    int p;

    // reset and lock
    do_reset();
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_last", int'(last_count), 0);
    drive(1, 1, 3);
    drive(1, 1, 4);
    check_val("not_yet_locked", int'(locked), 0);
    drive(1, 1, 5);
    check_val("locked_after_5", int'(locked), 1);

    // wrap
    for (int i = 6; i <= 15; i++) drive(1, 1, i);
    check_val("no_wrap_yet", int'(wrap_cnt), 0);
    drive(1, 1, 0);
    check_val("wrap_pulse_0", int'(wrap_pulse), 1);
    check_val("wrap_cnt_1", int'(wrap_cnt), 1);
    drive(1, 1, 1);
    check_val("wrap_single", int'(wrap_pulse), 0);
    check_val("wrap_locked", int'(locked), 1);

    // skip error
    for (int i = 2; i <= 7; i++) drive(1, 1, i);
    drive(1, 1, 9);
    check_val("skip_err_pulse", int'(err_pulse), 1);
    check_val("skip_err_cnt", int'(err_cnt), 1);
    check_val("skip_unlock", int'(locked), 0);
    drive(1, 1, 10);
    check_val("skip_acq", int'(locked), 0);
    drive(1, 1, 11);
    check_val("skip_relock", int'(locked), 1);

    // stall then restart
    do_reset();
    drive(1, 1, 2); drive(1, 1, 3); drive(1, 1, 4);
    drive(1, 1, 4);
    check_val("stall_err_pulse", int'(err_pulse), 1);
    check_val("stall_err_cnt", int'(err_cnt), 1);
    drive(1, 1, 5); drive(1, 1, 6);
    check_val("stall_relock", int'(locked), 1);
    drive(1, 1, 7);
    drive(1, 1, 0);
    check_val("restart_pulse", int'(restart_pulse), 1);
    check_val("restart_no_err", int'(err_pulse), 0);
    check_val("restart_cnt_1", int'(restart_cnt), 1);
    check_val("restart_err_cnt", int'(err_cnt), 1);

    // saturation via repeated skips (never skipping onto 0)
    do_reset();
    v = 1;
    drive(1, 1, v);
    v = (v + 1) % 16; drive(1, 1, v);
    v = (v + 1) % 16; drive(1, 1, v);
    for (int k = 0; k < 300; k++) begin
      v = (v + 2) % 16;
      if (v == 0) v = 1;
      drive(1, 1, v);
      v = (v + 1) % 16; drive(1, 1, v);
      v = (v + 1) % 16; drive(1, 1, v);
    end
    check_val("err_sat_255", int'(err_cnt), 255);

    // enable drop mid-stream
    v = (v + 1) % 16; drive(1, 1, v);
    check_val("pre_drop_locked", int'(locked), 1);
    p = v;
    drive(1, 0, (v + 5) % 16);
    check_val("drop_unlock", int'(locked), 0);
    check_val("drop_last_frozen", int'(last_count), p);
    check_val("drop_err_hold", int'(err_cnt), 255);
    drive(1, 0, 3);
    check_val("drop_last_frozen2", int'(last_count), p);

    // mid-run reset with three errors
    do_reset();
    v = 2;
    drive(1, 1, v); drive(1, 1, v + 1); drive(1, 1, v + 2);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 12); drive(1, 1, 13); drive(1, 1, 14);
    end
    check_val("mid_err_3", int'(err_cnt), 3);
    check_val("mid_locked", int'(locked), 1);
    drive(0, 1, 15);
    check_val("mid_rst_locked", int'(locked), 0);
    check_val("mid_rst_err", int'(err_cnt), 0);
    check_val("mid_rst_wrap", int'(wrap_cnt), 0);
    check_val("mid_rst_last", int'(last_count), 0);
    drive(1, 1, 8); drive(1, 1, 9);
    check_val("mid_relock_wait", int'(locked), 0);
    drive(1, 1, 10);
    check_val("mid_relock", int'(locked), 1);

    // randomized stream with occasional faults
    v = 0;
    for (int k = 0; k < 4000; k++) begin
      int  sel;
      bit  r, e;
      r   = 1;
      e   = 1;
      sel = $urandom_range(0, 199);
      if (sel < 160)      v = (v + 1) % 16;
      else if (sel < 170) v = (v + $urandom_range(2, 14)) % 16;
      else if (sel < 178) v = v;
      else if (sel < 186) v = 0;
      else if (sel < 194) e = 0;
      else if (sel < 198) v = $urandom_range(0, 15);
      else                r = 0;
      drive(r, e, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
